// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer engine.
// Build option: RT_BEST_TIME_EN adds per-player personal-best tracking in the top.
// No logic here; types and constants only.
package rt_pkg;

   // Round sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GO   = 2'd2,
      DONE = 2'd3
   } rt_state_t;

   // Width of a player index (up to 8 players)
   localparam int IDX_W = 3;

   // "No result" marker at the default result width
   localparam int RT_CNT_W = 16;
   localparam logic [RT_CNT_W-1:0] RES_NONE = '1;

endpackage

// File: rtl/rt_min_select.sv
// Purpose: argmin over N packed values under a valid mask, lowest index wins ties.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the inputs continuously.
module rt_min_select
   import rt_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 16
) (
   input  logic [N*W-1:0]   vals,
   input  logic [N-1:0]     valid,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [W-1:0] best_v;

   // Upward scan; strict less-than keeps the earliest index on equal values
   always_comb begin
      idx    = '0;
      found  = 1'b0;
      best_v = '0;
      for (int i = 0; i < N; i++) begin
         if (valid[i] && (!found || (vals[i*W +: W] < best_v))) begin
            found  = 1'b1;
            best_v = vals[i*W +: W];
            idx    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/reaction_timer_core.sv
// Purpose: multi-player reaction timer (random arm delay, timing, false starts, winner); RT_BEST_TIME_EN adds personal bests.
// Latency: one 100 Hz tick per state step; results and winner valid from the first DONE cycle.
// Backpressure: none; inputs are sampled every tick and results hold until the next start edge.
module reaction_timer_core
   import rt_pkg::*;
#(
   parameter int N_PLAYERS = 2,
   parameter int CNT_W     = 16,
   parameter int RND_W     = 10,
   parameter int MIN_DELAY = 50,
   parameter int TIMEOUT   = 999   // must stay below 2**CNT_W-1 so it never aliases the no-result code
) (
   input  logic                       clk100hz,
   input  logic                       rst,
   input  logic                       start,
   input  logic [RND_W-1:0]           rnd,
   input  logic [N_PLAYERS-1:0]       resp,
   output logic                       go_led,
   output logic                       busy,
   output logic                       done,
   output logic [N_PLAYERS-1:0]       false_start,
   output logic [N_PLAYERS*CNT_W-1:0] times,
   output logic [IDX_W-1:0]           winner,
   output logic                       winner_valid
`ifdef RT_BEST_TIME_EN
   ,output logic [N_PLAYERS*CNT_W-1:0] best
`endif
);

   // Same all-ones code as RES_NONE, sized to this instance's result width
   localparam logic [CNT_W-1:0] NO_RESULT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);

   rt_state_t                  state, state_nxt;
   logic                       start_q;
   logic [N_PLAYERS-1:0]       resp_q;
   logic                       start_edge;
   logic [N_PLAYERS-1:0]       resp_edge;
   logic [RND_W:0]             delay_cnt, delay_nxt;
   logic [CNT_W-1:0]           elapsed, elapsed_nxt;
   logic [N_PLAYERS-1:0]       resolved, res_nxt;
   logic [N_PLAYERS-1:0]       fs_nxt;
   logic [N_PLAYERS*CNT_W-1:0] times_nxt;
   logic [N_PLAYERS-1:0]       elig;
   logic                       done_entry;
   logic                       round_start;
   logic [IDX_W-1:0]           sel_idx;
   logic                       sel_found;

   assign start_edge  = start & ~start_q;
   assign resp_edge   = resp & ~resp_q;
   assign round_start = start_edge && ((state == IDLE) || (state == DONE));
   assign done_entry  = (state_nxt == DONE) && (state != DONE);

   // go_led is gated by rst so it drops in the same tick reset is raised
   assign go_led = (state == GO) && !rst;
   assign busy   = (state == ARM) || (state == GO);
   assign done   = (state == DONE);

   // State register
   always_ff @(posedge clk100hz) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Previous-tick copies of start and buttons for rising-edge detection
   always_ff @(posedge clk100hz) begin
      if (rst) begin
         start_q <= 1'b0;
         resp_q  <= '0;
      end else begin
         start_q <= start;
         resp_q  <= resp;
      end
   end

   // Next state and next round datapath (delay, elapsed, per-player results)
   always_comb begin
      state_nxt   = state;
      delay_nxt   = delay_cnt;
      elapsed_nxt = elapsed;
      res_nxt     = resolved;
      fs_nxt      = false_start;
      times_nxt   = times;
      case (state)
         IDLE, DONE: begin
            if (start_edge) begin
               delay_nxt   = (RND_W+1)'(MIN_DELAY) + {1'b0, rnd};
               elapsed_nxt = '0;
               res_nxt     = '0;
               fs_nxt      = '0;
               times_nxt   = {N_PLAYERS{NO_RESULT}};
               state_nxt   = ARM;
            end
         end
         ARM: begin
            delay_nxt = delay_cnt - 1'b1;
            fs_nxt    = false_start | resp_edge;
            res_nxt   = resolved | resp_edge;
            if (&res_nxt) begin
               state_nxt = DONE;
            end else if (delay_cnt <= (RND_W+1)'(1)) begin
               elapsed_nxt = '0;
               state_nxt   = GO;
            end
         end
         GO: begin
            if (elapsed != TMO) elapsed_nxt = elapsed + 1'b1;
            for (int i = 0; i < N_PLAYERS; i++) begin
               if (resp_edge[i] && !resolved[i]) begin
                  times_nxt[i*CNT_W +: CNT_W] = elapsed;
                  res_nxt[i]                  = 1'b1;
               end
            end
            if (elapsed == TMO) begin
               for (int i = 0; i < N_PLAYERS; i++) begin
                  if (!res_nxt[i]) begin
                     times_nxt[i*CNT_W +: CNT_W] = TMO;
                     res_nxt[i]                  = 1'b1;
                  end
               end
            end
            if (&res_nxt) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Round datapath registers
   always_ff @(posedge clk100hz) begin
      if (rst) begin
         delay_cnt   <= '0;
         elapsed     <= '0;
         resolved    <= '0;
         false_start <= '0;
         times       <= {N_PLAYERS{NO_RESULT}};
      end else begin
         delay_cnt   <= delay_nxt;
         elapsed     <= elapsed_nxt;
         resolved    <= res_nxt;
         false_start <= fs_nxt;
         times       <= times_nxt;
      end
   end

   // A player qualifies with no false start and a time strictly under the timeout
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         elig[i] = !fs_nxt[i] && (times_nxt[i*CNT_W +: CNT_W] < TMO);
      end
   end

   rt_min_select #(.N(N_PLAYERS), .W(CNT_W)) u_win_sel (
      .vals  (times_nxt),
      .valid (elig),
      .idx   (sel_idx),
      .found (sel_found)
   );

   // Winner latched on the DONE entry edge, cleared when a new round starts
   always_ff @(posedge clk100hz) begin
      if (rst) begin
         winner       <= '0;
         winner_valid <= 1'b0;
      end else if (done_entry) begin
         winner       <= sel_found ? sel_idx : '0;
         winner_valid <= sel_found;
      end else if (round_start) begin
         winner       <= '0;
         winner_valid <= 1'b0;
      end
   end

`ifdef RT_BEST_TIME_EN
   logic [N_PLAYERS-1:0] best_upd;

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_best
      logic [IDX_W-1:0] b_idx;
      logic             b_found;
      // Slot 0 is the stored best (always valid), slot 1 this round's time
      rt_min_select #(.N(2), .W(CNT_W)) u_best_sel (
         .vals  ({times_nxt[g*CNT_W +: CNT_W], best[g*CNT_W +: CNT_W]}),
         .valid ({elig[g], 1'b1}),
         .idx   (b_idx),
         .found (b_found)
      );
      assign best_upd[g] = b_found && (b_idx == IDX_W'(1));
   end

   // Personal bests persist across rounds; only rst clears them
   always_ff @(posedge clk100hz) begin
      if (rst) begin
         best <= '1;
      end else if (done_entry) begin
         for (int i = 0; i < N_PLAYERS; i++) begin
            if (best_upd[i]) best[i*CNT_W +: CNT_W] <= times_nxt[i*CNT_W +: CNT_W];
         end
      end
   end
`endif

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: hand-computed round table, corner sequences, randomized rounds vs a reference model.
// Timing: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Build with RT_BEST_TIME_EN defined to also exercise the personal-best output.
module tb_reaction_timer_core;

   localparam int N         = 2;
   localparam int CW        = 16;
   localparam int RW        = 10;
   localparam int MIN_DELAY = 50;
   localparam int TIMEOUT   = 999;

   logic            clk100hz = 1'b0;
   logic            rst;
   logic            start;
   logic [RW-1:0]   rnd;
   logic [N-1:0]    resp;
   logic            go_led;
   logic            busy;
   logic            done;
   logic [N-1:0]    false_start;
   logic [N*CW-1:0] times;
   logic [2:0]      winner;
   logic            winner_valid;
`ifdef RT_BEST_TIME_EN
   logic [N*CW-1:0] best;
`endif

   reaction_timer_core #(
      .N_PLAYERS(N), .CNT_W(CW), .RND_W(RW), .MIN_DELAY(MIN_DELAY), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk100hz     (clk100hz),
      .rst          (rst),
      .start        (start),
      .rnd          (rnd),
      .resp         (resp),
      .go_led       (go_led),
      .busy         (busy),
      .done         (done),
      .false_start  (false_start),
      .times        (times),
      .winner       (winner),
      .winner_valid (winner_valid)
`ifdef RT_BEST_TIME_EN
      ,.best        (best)
`endif
   );

   always #5 clk100hz = ~clk100hz;

   // One round: press edges p0/p1 counted in ticks after the start edge (0 = never pressed)
   typedef struct {
      logic [RW-1:0] rnd;
      int            p0;
      int            p1;
      logic [CW-1:0] t0;
      logic [CW-1:0] t1;
      logic [1:0]    fs;
      logic [2:0]    win;
      logic          wv;
      int            done_k;
      int            go_k;   // 0 = go_led never rises
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk100hz);
      #1;
   endtask

   // Reference model: derives the round outcome from the game rules with plain arithmetic
   function automatic vec_t model(input logic [RW-1:0] r, input int p0, input int p1);
      vec_t v;
      int   d;
      int   p [2];
      int   t [2];
      bit   fsb [2];
      int   rmax;
      int   bestt;
      bit   all_fs;
      v.rnd = r; v.p0 = p0; v.p1 = p1;
      d = MIN_DELAY + int'(r);
      p[0] = p0; p[1] = p1;
      rmax = 0;
      for (int i = 0; i < 2; i++) begin
         fsb[i] = (p[i] != 0) && (p[i] <= d);
         if (fsb[i])                                      t[i] = -1;
         else if ((p[i] != 0) && (p[i] - d - 1 <= TIMEOUT)) t[i] = p[i] - d - 1;
         else                                             t[i] = TIMEOUT;
         if (p[i] == 0)        rmax = 1 << 30;
         else if (p[i] > rmax) rmax = p[i];
      end
      all_fs   = fsb[0] && fsb[1];
      v.go_k   = all_fs ? 0 : d;
      v.done_k = (all_fs || rmax < d + TIMEOUT + 1) ? rmax : d + TIMEOUT + 1;
      v.t0     = fsb[0] ? '1 : CW'(t[0]);
      v.t1     = fsb[1] ? '1 : CW'(t[1]);
      v.fs     = {fsb[1], fsb[0]};
      v.win    = 3'd0;
      v.wv     = 1'b0;
      bestt    = 1 << 30;
      for (int i = 0; i < 2; i++) begin
         if (!fsb[i] && t[i] < TIMEOUT && t[i] < bestt) begin
            bestt = t[i];
            v.win = 3'(i);
            v.wv  = 1'b1;
         end
      end
      return v;
   endfunction

   function automatic int gen_p(input int d);
      int m;
      m = int'($urandom_range(0, 9));
      if (m == 0) return 0;
      if (m <= 2) return int'($urandom_range(1, d));
      if (m == 3) return d + int'($urandom_range(995, 1003));
      return d + 1 + int'($urandom_range(0, 300));
   endfunction

   // Plays one round from IDLE or DONE and compares against the expected record
   task automatic run_round(input vec_t v, input string tag);
      int go_seen;
      int done_seen;
      int budget;
      resp  = '0;
      rnd   = v.rnd;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_after_start"}, {busy, done}, 2'b10);
      go_seen   = 0;
      done_seen = 0;
      budget    = MIN_DELAY + int'(v.rnd) + TIMEOUT + 100;
      for (int k = 1; k <= budget && done_seen == 0; k++) begin
         resp[0] = (v.p0 != 0) && (k >= v.p0);
         resp[1] = (v.p1 != 0) && (k >= v.p1);
         tick();
         if (go_led && go_seen == 0) go_seen = k;
         if (done) done_seen = k;
      end
      check({tag, "_go_tick"},   go_seen,      v.go_k);
      check({tag, "_done_tick"}, done_seen,    v.done_k);
      check({tag, "_times0"},    times[15:0],  v.t0);
      check({tag, "_times1"},    times[31:16], v.t1);
      check({tag, "_false"},     false_start,  v.fs);
      check({tag, "_wvalid"},    winner_valid, v.wv);
      check({tag, "_winner"},    winner,       v.win);
      resp = '0;
   endtask

   task automatic wait_go(input string tag);
      int seen;
      seen = 0;
      for (int k = 0; k < 2000 && seen == 0; k++) begin
         tick();
         if (go_led) seen = 1;
      end
      check({tag, "_go_reached"}, seen, 1);
   endtask

   vec_t tbl [10];
   vec_t rv;

   initial begin
      // order: rnd, p0, p1, t0, t1, fs, win, wv, done_k, go_k
      tbl[0] = '{10'd20, 0,    0,  16'd999, 16'd999, 2'b00, 3'd0, 1'b0, 1070, 70};
      tbl[1] = '{10'd0,  81,   96, 16'd30,  16'd45,  2'b00, 3'd0, 1'b1, 96,   50};
      tbl[2] = '{10'd5,  68,   20, 16'd12,  16'hFFFF,2'b10, 3'd0, 1'b1, 68,   55};
      tbl[3] = '{10'd10, 30,   40, 16'hFFFF,16'hFFFF,2'b11, 3'd0, 1'b0, 40,   0};
      tbl[4] = '{10'd7,  83,   83, 16'd25,  16'd25,  2'b00, 3'd0, 1'b1, 83,   57};
      tbl[5] = '{10'd3,  154,  61, 16'd100, 16'd7,   2'b00, 3'd1, 1'b1, 154,  53};
      tbl[6] = '{10'd0,  1049, 0,  16'd998, 16'd999, 2'b00, 3'd0, 1'b1, 1050, 50};
      tbl[7] = '{10'd0,  1050, 0,  16'd999, 16'd999, 2'b00, 3'd0, 1'b0, 1050, 50};
      tbl[8] = '{10'd0,  51,   50, 16'd0,   16'hFFFF,2'b10, 3'd0, 1'b1, 51,   50};
      tbl[9] = '{10'd1,  10,   85, 16'hFFFF,16'd33,  2'b01, 3'd1, 1'b1, 85,   51};

      rst = 1'b1; start = 1'b0; rnd = '0; resp = '0;
      tick(); tick();
      check("reset_go_led", go_led,       0);
      check("reset_busy",   busy,         0);
      check("reset_done",   done,         0);
      check("reset_false",  false_start,  0);
      check("reset_times",  times,        {N*CW{1'b1}});
      check("reset_winner", {winner_valid, winner}, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) run_round(tbl[i], $sformatf("tbl%0d", i));

      // Repeat press from an already-resolved player is ignored
      rnd = '0; start = 1'b1; tick(); start = 1'b0;
      wait_go("repeat");
      repeat (10) tick();
      resp = 2'b01; tick();
      resp = 2'b00; repeat (4) tick();
      resp = 2'b01; tick();
      resp = 2'b11; tick();
      check("repeat_done",   done,         1);
      check("repeat_times0", times[15:0],  10);
      check("repeat_times1", times[31:16], 16);
      check("repeat_winner", {winner_valid, winner}, 4'b1000);
      resp = '0;

      for (int i = 0; i < 12; i++) begin
         logic [RW-1:0] r;
         int d;
         r  = RW'($urandom_range(0, (1 << RW) - 1));
         d  = MIN_DELAY + int'(r);
         rv = model(r, gen_p(d), gen_p(d));
         run_round(rv, $sformatf("rand%0d", i));
      end

      // Start edge in GO ignored, then reset mid-GO
      rnd = '0; start = 1'b1; tick(); start = 1'b0;
      wait_go("midgo");
      repeat (5) tick();
      start = 1'b1; tick(); start = 1'b0;
      check("midgo_start_ignored", {busy, go_led, done}, 3'b110);
      resp = 2'b01; tick();
      check("midgo_times0", times[15:0], 6);
      check("midgo_not_done", done, 0);
      rst = 1'b1;
      #1;
      check("midgo_go_drop", go_led, 0);
      tick();
      check("midgo_rst_state", {busy, done, go_led}, 0);
      check("midgo_rst_times", times, {N*CW{1'b1}});
      check("midgo_rst_false", {false_start, winner_valid}, 0);
      rst = 1'b0; resp = '0;
      tick();

`ifdef RT_BEST_TIME_EN
      check("best_reset", best, {N*CW{1'b1}});
      run_round(model(10'd0, 91, 0), "best40");
      check("best_after40_p0", best[15:0],  40);
      check("best_after40_p1", best[31:16], 16'hFFFF);
      run_round(model(10'd0, 76, 0), "best25");
      check("best_after25_p0", best[15:0],  25);
      run_round(model(10'd0, 111, 0), "best60");
      check("best_after60_p0", best[15:0],  25);
      check("best_after60_p1", best[31:16], 16'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
Multi-player reaction-timer engine running on the 100 Hz tick domain; a successor to the single-player game logic.
- Arms on `start` and waits a random delay, then asserts `go_led`.
- Times each player's response in 10 ms ticks and flags false starts.
- Applies a timeout and picks the winner.
- Results feed the existing binary-to-BCD and 7-segment display path.

Parameters:
- N_PLAYERS, 2, number of response inputs (1..8)
- CNT_W, 16, width of each reaction-time result
- RND_W, 10, width of the random-delay input
- MIN_DELAY, 50, fixed ticks added to the random delay (0.5 s)
- TIMEOUT, 999, max measurable ticks; must be < 2^CNT_W-1

Ports:
- clk100hz  in  1  100 Hz tick clock
- rst  in  1  synchronous, active-high reset
- start  in  1  round start/restart request, level-synchronised, active-high
- rnd  in  RND_W  free-running random value from the LFSR generator
- resp  in  N_PLAYERS  player buttons, debounced/synchronised, active-high
- go_led  out  1  high while measuring
- busy  out  1  high in ARM or GO
- done  out  1  high in DONE
- false_start  out  N_PLAYERS  per-player false-start flag
- times  out  N_PLAYERS*CNT_W  per-player result, player i at [i*CNT_W +: CNT_W]
- winner  out  3  index of fastest valid player
- winner_valid  out  1  a winner exists

Behaviour:
- FSM states: IDLE, ARM, GO, DONE. Reset enters IDLE.
- Reset values: all outputs 0 except `times`, which resets to all-ones (RES_NONE).
- `start` is edge-detected internally (`start & ~start_q`). `resp` is edge-detected per bit the same way. Only rising edges count.
- IDLE, on start edge:
  - delay_cnt <= MIN_DELAY + rnd (zero-extended, width RND_W+1).
  - Clear false_start, resolved mask, times (to RES_NONE), winner_valid.
  - Go to ARM.
- ARM:
  - delay_cnt decrements each tick.
  - A resp edge on player i sets false_start[i] and resolved[i]; times[i] stays RES_NONE.
  - If all players are resolved, go to DONE.
  - When delay_cnt==1 and not all resolved, go to GO on the next edge with elapsed <= 0.
- GO:
  - go_led=1; elapsed increments by 1 per tick.
  - A resp edge on an unresolved player i captures times[i] <= elapsed (the value before this edge's increment) and sets resolved[i].
  - Simultaneous edges from several players are each captured with the same value.
  - A repeat press from a resolved player is ignored.
  - If all players are resolved after this edge, go to DONE.
  - If elapsed==TIMEOUT, every unresolved player gets times=TIMEOUT, resolved=1, and the FSM goes to DONE.
- DONE:
  - go_led=0, done=1.
  - Results hold until the next start edge, which behaves exactly as the IDLE start edge.
- Start edges in ARM or GO are ignored.
- Winner:
  - Registered on the DONE entry edge, so valid from the first DONE cycle.
  - Selected as the minimum `times` among players with false_start=0 and times<TIMEOUT.
  - Ties go to the lowest index.
  - If no player qualifies: winner_valid=0, winner=0.
- rst mid-round: return to IDLE next edge; all state cleared; go_led drops immediately.
- Arithmetic: elapsed saturates at TIMEOUT and never wraps; the delay sum cannot overflow by construction.

Optional Feature:
- Macro: RT_BEST_TIME_EN.
- With it defined:
  - Adds output `best` (N_PLAYERS*CNT_W), a per-player personal best.
  - On DONE entry, best[i] <= min(best[i], times[i]) for players with no false start and times<TIMEOUT.
  - `best` resets to all-ones and only `rst` clears it; rounds do not.
- Without it: no port, no registers.

Decomposition:
- Package rt_pkg holds:
  - state enum rt_state_t {IDLE, ARM, GO, DONE}
  - constant RES_NONE (all-ones, CNT_W)
  - localparam IDX_W=3
- One sub-module, rt_min_select: combinational argmin over N_PLAYERS values with a valid mask and lowest-index tie break. It is reused by the best-time logic.

Test Plan:
- N=2, rnd=20, start edge, no presses:
  - go_led rises 70 ticks after start.
  - At elapsed 999: times both 999, DONE, winner_valid=0.
- rnd=0, P0 presses 30 ticks after go_led, P1 at 45:
  - times = {45, 30}, winner=0, winner_valid=1, done on the P1 press edge.
- P1 presses during ARM, P0 at 12 after go:
  - false_start=2'b10, times[1]=RES_NONE, times[0]=12, winner=0.
- Both players press during ARM:
  - DONE without go_led ever rising; winner_valid=0.
- Both press on the same go-relative tick 25:
  - times both 25, winner=0 (tie goes to the lower index).
- Reset and restart:
  - rst asserted mid-GO: next cycle IDLE, go_led=0, times all-ones.
  - A start edge in GO is ignored.
  - With RT_BEST_TIME_EN: rounds of 40 then 25 give best[0]=25, and a later round of 60 leaves best[0]=25.
